// File: rtl/onchip_mem_arbiter_pkg.sv
// Shared constants and state type for the on-chip RAM arbiter.
package onchip_mem_pkg;

  localparam int unsigned MEM_ADDR_W = 11;
  localparam int unsigned MEM_DATA_W = 32;
  localparam int unsigned MEM_DEPTH  = 2048;

  typedef enum logic [0:0] {
    ARB,
    CLEAR
  } arb_state_t;

endpackage

// File: rtl/onchip_mem_arbiter_rr_grant.sv
// Combinational round-robin picker: first set request at or above ptr_i, with wrap.
module rr_grant #(
  parameter int unsigned N    = 2,
  parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]    req_i,
  input  logic [IdxW-1:0] ptr_i,
  output logic [N-1:0]    gnt_o,
  output logic [IdxW-1:0] gnt_idx_o,
  output logic            gnt_valid_o
);

  // Walk offsets 0..N-1 from the pointer; the first active slot wins.
  always_comb begin
    gnt_o       = '0;
    gnt_idx_o   = '0;
    gnt_valid_o = 1'b0;
    for (int unsigned k = 0; k < N; k++) begin
      for (int unsigned j = 0; j < N; j++) begin
        if (!gnt_valid_o && req_i[j] && ((32'(ptr_i) + k) % N == j)) begin
          gnt_valid_o = 1'b1;
          gnt_o[j]    = 1'b1;
          gnt_idx_o   = IdxW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/onchip_mem_arbiter.sv
// Round-robin arbiter sharing one single-port RAM among NUM_REQ Avalon-MM
// requesters, with a sequencer that fills the whole RAM while stalling everyone.
module onchip_mem_arbiter
  import onchip_mem_pkg::*;
#(
  parameter int unsigned       NUM_REQ = 2,
  parameter int unsigned       ADDR_W  = MEM_ADDR_W,
  parameter int unsigned       DATA_W  = MEM_DATA_W,
  parameter int unsigned       DEPTH   = MEM_DEPTH,
  parameter logic [DATA_W-1:0] FILL    = '0,
  localparam int unsigned      BE_W    = DATA_W / 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQ*ADDR_W-1:0] req_address,
  input  logic [NUM_REQ*BE_W-1:0]   req_byteenable,
  input  logic [NUM_REQ-1:0]        req_read,
  input  logic [NUM_REQ-1:0]        req_write,
  input  logic [NUM_REQ*DATA_W-1:0] req_writedata,
  output logic [NUM_REQ-1:0]        req_waitrequest,
  output logic [DATA_W-1:0]         req_readdata,
  output logic [NUM_REQ-1:0]        req_readdatavalid,
  output logic [ADDR_W-1:0]         mem_address,
  output logic [BE_W-1:0]           mem_byteenable,
  output logic                      mem_chipselect,
  output logic                      mem_write,
  output logic [DATA_W-1:0]         mem_writedata,
  output logic                      mem_clken,
  input  logic [DATA_W-1:0]         mem_readdata,
  input  logic                      clear_start,
  output logic                      clear_busy,
  output logic                      clear_done
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  // One spare bit so DEPTH == 2**ADDR_W still has a distinct terminal count.
  localparam int unsigned CNT_W = ADDR_W + 1;

  arb_state_t       state_q;
  logic [IDX_W-1:0] rr_ptr_q;
  logic             pend_valid_q;
  logic [IDX_W-1:0] pend_id_q;
  logic [CNT_W-1:0] clr_cnt_q;
  logic             clear_busy_q;
  logic             clear_done_q;

  logic [NUM_REQ-1:0] active;
  logic [NUM_REQ-1:0] gnt_oh;
  logic [IDX_W-1:0]   gnt_idx;
  logic               gnt_valid;
  logic               arb_en;
  logic               accept_read;

  logic [ADDR_W-1:0] sel_addr;
  logic [BE_W-1:0]   sel_be;
  logic [DATA_W-1:0] sel_wd;
  logic              sel_rd;
  logic              sel_wr;

  assign active = req_read | req_write;

  rr_grant #(
    .N    (NUM_REQ),
    .IdxW (IDX_W)
  ) u_rr_grant (
    .req_i       (active),
    .ptr_i       (rr_ptr_q),
    .gnt_o       (gnt_oh),
    .gnt_idx_o   (gnt_idx),
    .gnt_valid_o (gnt_valid)
  );

  // A grant is only real when arbitrating and not held in reset.
  assign arb_en = !reset && (state_q == ARB) && gnt_valid;
  // Read+write together is treated as a write, so it never returns data.
  assign accept_read = arb_en && sel_rd && !sel_wr;

  // One-hot mux of the granted requester's command.
  always_comb begin
    sel_addr = '0;
    sel_be   = '0;
    sel_wd   = '0;
    sel_rd   = 1'b0;
    sel_wr   = 1'b0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (gnt_oh[i]) begin
        sel_addr = req_address[i*ADDR_W +: ADDR_W];
        sel_be   = req_byteenable[i*BE_W +: BE_W];
        sel_wd   = req_writedata[i*DATA_W +: DATA_W];
        sel_rd   = req_read[i];
        sel_wr   = req_write[i];
      end
    end
  end

  // RAM-side command and requester stalls.
  always_comb begin
    req_waitrequest = '1;
    mem_address     = sel_addr;
    mem_byteenable  = sel_be;
    mem_writedata   = sel_wd;
    mem_chipselect  = 1'b0;
    mem_write       = 1'b0;
    if (reset) begin
      // everyone stalled, RAM idle
    end else if (state_q == CLEAR) begin
      mem_chipselect = 1'b1;
      mem_write      = 1'b1;
      mem_byteenable = '1;
      mem_address    = clr_cnt_q[ADDR_W-1:0];
      mem_writedata  = FILL;
    end else if (gnt_valid) begin
      req_waitrequest = ~gnt_oh;
      mem_chipselect  = 1'b1;
      mem_write       = sel_wr;
    end
  end

  // Read data valid strobe goes to whoever owns the read accepted last cycle.
  always_comb begin
    req_readdatavalid = '0;
    if (pend_valid_q) begin
      req_readdatavalid[pend_id_q] = 1'b1;
    end
  end

  assign req_readdata = mem_readdata;
  assign mem_clken    = 1'b1;
  assign clear_busy   = clear_busy_q;
  assign clear_done   = clear_done_q;

  // Arbitration pointer, pending-read tracking and the clear FSM.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ARB;
      rr_ptr_q     <= '0;
      pend_valid_q <= 1'b0;
      pend_id_q    <= '0;
      clr_cnt_q    <= '0;
      clear_busy_q <= 1'b0;
      clear_done_q <= 1'b0;
    end else begin
      pend_valid_q <= accept_read;
      if (accept_read) begin
        pend_id_q <= gnt_idx;
      end
      if (arb_en) begin
        rr_ptr_q <= (gnt_idx == IDX_W'(NUM_REQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      clear_done_q <= 1'b0;
      case (state_q)
        ARB: begin
          if (clear_start) begin
            state_q      <= CLEAR;
            clr_cnt_q    <= '0;
            clear_busy_q <= 1'b1;
          end
        end
        CLEAR: begin
          clr_cnt_q <= clr_cnt_q + 1'b1;
          if (clr_cnt_q == CNT_W'(DEPTH - 1)) begin
            state_q      <= ARB;
            clear_busy_q <= 1'b0;
            clear_done_q <= 1'b1;
          end
        end
        default: begin
          state_q      <= ARB;
          clear_busy_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: doc/onchip_mem_arbiter.md
Name: onchip_mem_arbiter

Overview:
- Shares one single-port on-chip RAM (2048 x 32, byte enables, 1-cycle read latency, RAM-internal address register, unregistered q) between NUM_REQ Avalon-MM requesters, e.g. the Nios II data master and the reaction-timer result logger.
- Round-robin grants one command per cycle, returns read data with readdatavalid, and includes a clear sequencer that zero-fills the whole RAM on request while all requesters are stalled.
- Sits between the requesters and the RAM's s1 slave port.

Parameters:
- NUM_REQ, 2, number of requesters; legal range 2..4.
- ADDR_W, 11, RAM word-address width.
- DATA_W, 32, data width; BE_W = DATA_W/8.
- DEPTH, 2048, words cleared by the sequencer; must be <= 2**ADDR_W.
- FILL, 0, DATA_W-bit value written during clear.

Ports:
- clk  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- req_address  in  NUM_REQ*ADDR_W  per-requester word address; requester i occupies slice [i*ADDR_W +: ADDR_W].
- req_byteenable  in  NUM_REQ*BE_W  per-requester byte enables.
- req_read  in  NUM_REQ  read command.
- req_write  in  NUM_REQ  write command.
- req_writedata  in  NUM_REQ*DATA_W  write data.
- req_waitrequest  out  NUM_REQ  low = command accepted this cycle.
- req_readdata  out  DATA_W  read data, shared bus, qualified per requester by readdatavalid.
- req_readdatavalid  out  NUM_REQ  one-cycle strobe to the requester owning the returned read.
- mem_address  out  ADDR_W  to RAM.
- mem_byteenable  out  BE_W  to RAM.
- mem_chipselect  out  1  to RAM.
- mem_write  out  1  to RAM.
- mem_writedata  out  DATA_W  to RAM.
- mem_clken  out  1  RAM clock enable; tied high.
- mem_readdata  in  DATA_W  RAM q.
- clear_start  in  1  one-cycle pulse; starts a zero-fill.
- clear_busy  out  1  high while the clear runs.
- clear_done  out  1  one-cycle pulse when the clear finishes.

Behaviour:
- Reset values: req_readdatavalid=0, clear_busy=0, clear_done=0, rr_ptr=0 (requester 0 has top priority), pend_valid=0, state=ARB.
- While reset is high, req_waitrequest is all-ones and mem_chipselect=0.
- States:
  - ARB: normal arbitration.
  - CLEAR: zero-fill in progress.
- ARB:
  - A requester is active when req_read|req_write is high.
  - Grant goes combinationally to the first active requester searching from rr_ptr upward with wrap.
  - The granted requester sees waitrequest=0 in the same cycle; all others see 1.
  - mem_* are driven combinationally from the granted requester, with mem_chipselect=1.
  - No active requester: mem_chipselect=0, mem_write=0.
  - On every grant, rr_ptr <= granted+1 mod NUM_REQ.
- Reads:
  - An accepted read registers pend_valid=1 and pend_id=granted.
  - Next cycle: req_readdatavalid[pend_id]=1 and req_readdata=mem_readdata. Latency is exactly 1 cycle after acceptance.
  - Back-to-back reads from any mix of requesters sustain 1 per cycle.
- Writes produce no readdatavalid.
- Read and write both high on one requester is a protocol violation: treat it as a write, no readdatavalid.
- clear_start in ARB: next cycle state=CLEAR, clear_busy=1, clr_cnt=0.
  - A read accepted in the same cycle as clear_start still returns its data on the following cycle.
- CLEAR:
  - All waitrequest=1.
  - Each cycle: mem_chipselect=1, mem_write=1, mem_byteenable=all-ones, mem_address=clr_cnt, mem_writedata=FILL; then clr_cnt++.
  - After the write at DEPTH-1: state=ARB, clear_busy=0, clear_done pulses 1 cycle. A clear takes exactly DEPTH cycles.
  - clr_cnt is ADDR_W+1 bits, so there is no wrap ambiguity.
- clear_start while clear_busy=1 is ignored.
- Reset during CLEAR aborts the clear immediately: no clear_done, RAM contents partially cleared.
- rr_ptr is unchanged by a clear.

Decomposition:
- Shared package onchip_mem_pkg holds:
  - constants MEM_ADDR_W=11, MEM_DATA_W=32, MEM_DEPTH=2048;
  - enum arb_state_t {ARB, CLEAR}.
- One natural sub-module, rr_grant: combinational round-robin priority picker (request vector plus rr_ptr in, one-hot grant plus index out), reusable elsewhere.

Test Plan:
- Single reads: req0 writes 0xDEADBEEF to addr 5 with be=4'hF; req0 reads addr 5 -> waitrequest low on the same cycle, readdatavalid[0] one cycle later, readdata=0xDEADBEEF, readdatavalid[1] stays 0.
- Contention: req0 and req1 both read every cycle for 6 cycles -> grants alternate 0,1,0,1,0,1 starting with req0 after reset; each readdatavalid arrives 1 cycle after its grant.
- Byte enables: write 0x11223344 to addr 7 with be=4'hF, then 0xAABBCCDD with be=4'b0101 -> read returns 0x11BB33DD.
- Clear: clear_start pulse -> clear_busy high for exactly 2048 cycles, requesters stalled throughout, clear_done pulses once; then reads of addrs 0, 5 and 2047 return 0.
- Clear collision: read accepted in the clear_start cycle -> data still returned next cycle; a second clear_start during the clear is ignored, giving one clear_done at cycle 2048.
- Reset mid-clear: reset asserted at clear cycle 100 -> clear_busy=0 next cycle, no clear_done, addr 50 reads 0, addr 1000 keeps its prior value, and req0 again has priority.
